matrix_subtraction: RTL and testbench
=====================================

# matrix_subtraction

Fixed-size element-wise matrix subtractor for the NPU datapath. It computes C = A − B over two 4×4 matrices of 8-bit operands and produces 16-bit results. The block is driven by a start/done handshake from the sequencing controller. It latches both operand matrices when `start` is accepted, processes one element per clock in row-major order, and holds the results and `done` until the next start.

## Interface
Parameters:
- `DIM`, 4 — rows and columns of the square matrices.
- `DATA_W`, 8 — operand element width.
- `OUT_W`, 16 — result element width; must be greater than `DATA_W`.

Ports:
- `clk`  in  1  — single clock; all logic is on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request to begin; sampled only in IDLE or DONE.
- `a`  in  `DATA_W` × [DIM][DIM]  — minuend matrix, unpacked.
- `b`  in  `DATA_W` × [DIM][DIM]  — subtrahend matrix, unpacked.
- `c`  out  `OUT_W` × [DIM][DIM]  — result matrix, registered.
- `done`  out  1  — results valid; level signal, sticky.

## Operation
- States:
  - IDLE (reset state).
  - RUN (element counter `idx` runs 0..DIM²−1).
  - DONE.
- IDLE or DONE with `start`=1:
  - Latch all of `a` and `b` into internal operand registers.
  - Set `idx`=0 and clear `done`.
  - Go to RUN.
- RUN, each cycle:
  - Write `c[idx/DIM][idx%DIM]` = latched `a` − latched `b` for that element.
  - Increment `idx`.
  - After writing `idx`=DIM²−1, go to DONE and set `done`=1.
- `start` during RUN is ignored. Changes on `a`/`b` after the start edge do not affect results.
- Arithmetic, default (unsigned operands):
  - Each operand is zero-extended to `OUT_W`, then subtracted modulo 2^`OUT_W`.
  - The result is two's complement, range −255..+255.
  - Examples: 3−1 = 0x0002; 0−1 = 0xFFFF.
- `c` elements not yet written in the current run keep their previous values. `c` is only valid while `done`=1.
- Reset, at any time including mid-RUN:
  - State goes to IDLE, `idx` and `done` to 0.
  - All `c` elements and operand registers go to 0.

## Timing
- Start accepted at edge k:
  - RUN occupies edges k+1 .. k+DIM².
  - `done` rises at edge k+DIM²+1, which is 17 cycles for DIM=4.
- `done` stays high until a new start is accepted or reset is applied.
- A back-to-back start in DONE is accepted on the same edge that clears `done`.
- `start` held high continuously produces a new run each time the block reaches DONE: one done cycle, then restart.
- Outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Configuration
- `MATRIX_SUB_SIGNED_EN` defined:
  - Operands are treated as signed two's complement and sign-extended to `OUT_W` before subtraction.
  - Example: 0x80 − 0x01 = −129 = 0xFF7F.
- `MATRIX_SUB_SIGNED_EN` undefined (default): operands are unsigned and zero-extended, as described above.
- Timing and handshake are identical in both builds.

## Structure
- Package `matrix_sub_pkg` holds:
  - Defaults for `DIM`, `DATA_W`, `OUT_W`.
  - The state enum `ms_state_t` {IDLE, RUN, DONE}.
  - A row/column index type.
- Sub-module `matrix_sub_elem`:
  - Purely combinational, one element.
  - Performs the widen (zero- or sign-extend per the macro) and the subtract.
  - A single instance is shared and muxed by `idx`.

## Test plan
- Reset, then idle:
  - Assert `rst` for 5 cycles, then release.
  - Required: `done`=0 and all `c`=0x0000.
- Basic:
  - Drive all `a`=0x03, all `b`=0x01, then a one-cycle `start`.
  - Required: `done` rises exactly 17 cycles after the start edge, and all 16 `c`=0x0002.
- Underflow:
  - Set `a`[i][j]=0x00, `b`[i][j]=0x01; also `a`=0x00, `b`=0xFF in row 3.
  - Required (default build): 0xFFFF, and 0xFF01 for row 3.
  - Required (`MATRIX_SUB_SIGNED_EN` build): 0x00 − 0xFF = +1 = 0x0001.
- Input isolation and busy-start:
  - After start, change `a` to 0x55 and pulse `start` mid-RUN.
  - Required: the results still use the latched values, and `done` timing is unchanged.
- Restart and reset:
  - With `done`=1, pulse `start` with new data. Required: `done` drops next cycle and new results appear 17 cycles later.
  - Assert `rst` mid-RUN. Required: all outputs return to 0 and `done` never asserts.

Source files
------------

// File: rtl/matrix_subtraction_pkg.sv
// matrix_sub_pkg: shared defaults, FSM state type and row/column index type for matrix_subtraction
package matrix_sub_pkg;
  localparam int DIM_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int OUT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} ms_state_t;
  typedef logic [$clog2(DIM_DEF)-1:0] rc_idx_t;
endpackage

// File: rtl/matrix_subtraction_elem.sv
// matrix_sub_elem: widen one operand pair to OUT_W and subtract; MATRIX_SUB_SIGNED_EN selects sign extension
module matrix_sub_elem #(
  parameter int DATA_W = 8,
  parameter int OUT_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [OUT_W-1:0]  o_d
);
  logic [OUT_W-1:0] w_a;
  logic [OUT_W-1:0] w_b;
`ifdef MATRIX_SUB_SIGNED_EN
  assign w_a = {{(OUT_W-DATA_W){i_a[DATA_W-1]}}, i_a};
  assign w_b = {{(OUT_W-DATA_W){i_b[DATA_W-1]}}, i_b};
`else
  assign w_a = {{(OUT_W-DATA_W){1'b0}}, i_a};
  assign w_b = {{(OUT_W-DATA_W){1'b0}}, i_b};
`endif
  assign o_d = w_a - w_b;
endmodule

// File: rtl/matrix_subtraction.sv
// matrix_subtraction: C = A - B over DIM x DIM matrices, one element per clock in row-major order
// MATRIX_SUB_SIGNED_EN switches the operands to signed two's complement
module matrix_subtraction
  import matrix_sub_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a [DIM][DIM],
  input  logic [DATA_W-1:0] b [DIM][DIM],
  output logic [OUT_W-1:0]  c [DIM][DIM],
  output logic              done
);
  localparam int N = DIM * DIM;
  localparam int IW = $clog2(N + 1);
  ms_state_t         r_state;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_a [DIM][DIM];
  logic [DATA_W-1:0] r_b [DIM][DIM];
  logic [OUT_W-1:0]  r_c [DIM][DIM];
  logic [OUT_W-1:0]  r_d;
  logic              r_done;
  logic [IW-1:0]     w_widx;
  rc_idx_t           w_row;
  rc_idx_t           w_col;
  rc_idx_t           w_wrow;
  rc_idx_t           w_wcol;
  logic [OUT_W-1:0]  w_d;
  // the shared subtractor is registered in r_d, so each result lands in c one edge after it is computed
  assign w_widx = r_idx - IW'(1);
  assign w_row = rc_idx_t'(r_idx / IW'(DIM));
  assign w_col = rc_idx_t'(r_idx % IW'(DIM));
  assign w_wrow = rc_idx_t'(w_widx / IW'(DIM));
  assign w_wcol = rc_idx_t'(w_widx % IW'(DIM));
  matrix_sub_elem #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_elem (
    .i_a(r_a[w_row][w_col]),
    .i_b(r_b[w_row][w_col]),
    .o_d(w_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_done <= 1'b0;
      r_d <= '0;
      r_a <= '{default: '0};
      r_b <= '{default: '0};
      r_c <= '{default: '0};
    end else if (r_state != RUN) begin
      if (start) begin
        r_a <= a;
        r_b <= b;
        r_idx <= '0;
        r_done <= 1'b0;
        r_state <= RUN;
      end
    end else begin
      if (r_idx != IW'(N)) r_d <= w_d;
      if (r_idx != '0) r_c[w_wrow][w_wcol] <= r_d;
      r_idx <= r_idx + IW'(1);
      if (r_idx == IW'(N)) begin
        r_state <= DONE;
        r_done <= 1'b1;
      end
    end
  end
  assign c = r_c;
  assign done = r_done;
endmodule

// File: tb/tb_matrix_subtraction.sv
// tb_matrix_subtraction: directed checks of timing, arithmetic, isolation, restart and reset
module tb_matrix_subtraction;
  logic clk = 1'b0;
  logic rst, start, done;
  logic [7:0] a [4][4];
  logic [7:0] b [4][4];
  logic [15:0] c [4][4];
  int tot = 0;
  int bad = 0;
  always #5 clk = ~clk;
  matrix_subtraction #(.DIM(4), .DATA_W(8), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .done(done)
  );
`ifdef MATRIX_SUB_SIGNED_EN
  localparam logic [15:0] EXP_ROW3 = 16'h0001;
  localparam logic [15:0] EXP_80 = 16'hFF7F;
`else
  localparam logic [15:0] EXP_ROW3 = 16'hFF01;
  localparam logic [15:0] EXP_80 = 16'h007F;
`endif
  task automatic fill(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = av;
        b[i][j] = bv;
      end
  endtask
  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    fill(8'h00, 8'h00);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    tot++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        tot++;
        if (c[i][j] !== 16'h0000) begin bad++; $display("FAIL reset_c[%0d][%0d] got %h want 0000", i, j, c[i][j]); end
      end
  endtask
  task automatic test_basic;
    int n;
    @(negedge clk) fill(8'h03, 8'h01);
    pulse_start;
    wait_done(0, n);
    tot++;
    if (n !== 17) begin bad++; $display("FAIL basic_latency got %0d want 17", n); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        tot++;
        if (c[i][j] !== 16'h0002) begin bad++; $display("FAIL basic_c[%0d][%0d] got %h want 0002", i, j, c[i][j]); end
      end
  endtask
  task automatic test_underflow;
    int n;
    logic [15:0] e;
    @(negedge clk) fill(8'h00, 8'h01);
    for (int j = 0; j < 4; j++) b[3][j] = 8'hFF;
    a[0][0] = 8'h80;
    b[0][0] = 8'h01;
    pulse_start;
    wait_done(0, n);
    tot++;
    if (n !== 17) begin bad++; $display("FAIL underflow_latency got %0d want 17", n); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        e = (i == 3) ? EXP_ROW3 : (i == 0 && j == 0) ? EXP_80 : 16'hFFFF;
        tot++;
        if (c[i][j] !== e) begin bad++; $display("FAIL underflow_c[%0d][%0d] got %h want %h", i, j, c[i][j], e); end
      end
  endtask
  task automatic test_isolation;
    int n;
    @(negedge clk) fill(8'h10, 8'h04);
    pulse_start;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) a[i][j] = 8'h55;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(4, n);
    tot++;
    if (n !== 17) begin bad++; $display("FAIL isolation_latency got %0d want 17", n); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        tot++;
        if (c[i][j] !== 16'h000C) begin bad++; $display("FAIL isolation_c[%0d][%0d] got %h want 000c", i, j, c[i][j]); end
      end
  endtask
  task automatic test_restart;
    int n;
    tot++;
    if (done !== 1'b1) begin bad++; $display("FAIL restart_pre_done got %b want 1", done); end
    @(negedge clk) fill(8'h20, 8'h07);
    pulse_start;
    tot++;
    if (done !== 1'b0) begin bad++; $display("FAIL restart_drop got %b want 0", done); end
    wait_done(0, n);
    tot++;
    if (n !== 17) begin bad++; $display("FAIL restart_latency got %0d want 17", n); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        tot++;
        if (c[i][j] !== 16'h0019) begin bad++; $display("FAIL restart_c[%0d][%0d] got %h want 0019", i, j, c[i][j]); end
      end
  endtask
  task automatic test_back_to_back;
    int n;
    @(negedge clk) begin
      fill(8'h09, 8'h02);
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    wait_done(0, n);
    tot++;
    if (n !== 17) begin bad++; $display("FAIL b2b_first_latency got %0d want 17", n); end
    @(posedge clk);
    #1;
    tot++;
    if (done !== 1'b0) begin bad++; $display("FAIL b2b_one_done_cycle got %b want 0", done); end
    wait_done(0, n);
    tot++;
    if (n !== 17) begin bad++; $display("FAIL b2b_second_latency got %0d want 17", n); end
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        tot++;
        if (c[i][j] !== 16'h0007) begin bad++; $display("FAIL b2b_c[%0d][%0d] got %h want 0007", i, j, c[i][j]); end
      end
  endtask
  task automatic test_reset_mid_run;
    logic seen;
    @(negedge clk) fill(8'h01, 8'h00);
    pulse_start;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tot++;
    if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got %b want 0", done); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        tot++;
        if (c[i][j] !== 16'h0000) begin bad++; $display("FAIL midrst_c[%0d][%0d] got %h want 0000", i, j, c[i][j]); end
      end
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    tot++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midrst_done_seen got %b want 0", seen); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_underflow;
    test_isolation;
    test_restart;
    test_back_to_back;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
